// File: rtl/mpram_pkg.sv
// Shared types for the LVT multi-port RAM: FSM states, LVT entry layout, select-width helper.
package mpram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Entry wide enough for the largest supported write-agent count (8)
  localparam int MAX_SEL_W = 3;

  typedef struct packed {
    logic                 written;
    logic [MAX_SEL_W-1:0] bank_idx;
  } lvt_entry_t;

  function automatic int select_width(input int nb_wragent);
    return (nb_wragent == 1) ? 1 : $clog2(nb_wragent);
  endfunction

endpackage

// File: rtl/mpram_lvt_core_if.sv
// Agent-side bus of the LVT multi-port RAM; flattened per-agent slices, agent i at [i*W +: W].
interface mpram_lvt_core_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NB_WRAGENT = 3,
  parameter int NB_RDAGENT = 2
) ();
  logic                           ready;
  logic [NB_WRAGENT-1:0]          wren;
  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr;
  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata;
  logic [NB_WRAGENT-1:0]          wrcollision;
  logic [NB_RDAGENT-1:0]          rden;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr;
  logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata;
  logic [NB_RDAGENT-1:0]          rdvalid;
  logic [NB_RDAGENT-1:0]          rdunwritten;

  modport master (
    input  ready, wrcollision, rddata, rdvalid, rdunwritten,
    output wren, wraddr, wrdata, rden, rdaddr
  );

  modport slave (
    input  wren, wraddr, wrdata, rden, rdaddr,
    output ready, wrcollision, rddata, rdvalid, rdunwritten
  );
endinterface

// File: rtl/mpram_lvt.sv
// Live-value table: per-address {written, bank} record, lowest-index write arbitration,
// and the post-reset INIT sweep that clears one entry per cycle before raising ready.
module mpram_lvt
  import mpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int NB_WRAGENT = 3,
  parameter int NB_RDAGENT = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_WRAGENT-1:0]          wr_en_i,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rd_addr_i,
  output logic                           ready_o,
  output logic [NB_WRAGENT-1:0]          wr_win_o,
  output logic [NB_WRAGENT-1:0]          wr_coll_o,
  output lvt_entry_t                     rd_ent_o [NB_RDAGENT]
);

  localparam int SELECT_WIDTH = select_width(NB_WRAGENT);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    init_clr;
  logic [NB_WRAGENT-1:0]   wr_en_g;
  logic                    written_q [RAM_DEPTH];
  logic [SELECT_WIDTH-1:0] sel_q     [RAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_IDX) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_o  = (state_q == ST_RUN);
    init_clr = (state_q == ST_INIT);
  end

  assign wr_en_g = wr_en_i & {NB_WRAGENT{ready_o & ~rst_i}};

  // A write loses if any lower-indexed enabled agent targets the same address
  always_comb begin
    wr_win_o  = '0;
    wr_coll_o = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      if (wr_en_g[i]) begin
        wr_win_o[i] = 1'b1;
        for (int k = 0; k < NB_WRAGENT; k++) begin
          if (k < i && wr_en_g[k] &&
              wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])
            wr_win_o[i] = 1'b0;
        end
        wr_coll_o[i] = ~wr_win_o[i];
      end
    end
  end

  // Winners hit distinct addresses, so the per-agent updates never overlap
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (init_clr) begin
        written_q[init_cnt_q] <= 1'b0;
        sel_q[init_cnt_q]     <= '0;
      end else begin
        for (int i = 0; i < NB_WRAGENT; i++) begin
          if (wr_win_o[i]) begin
            written_q[wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b1;
            sel_q[wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]]     <= SELECT_WIDTH'(i);
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NB_RDAGENT; j++) begin
      rd_ent_o[j].written  = written_q[rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]];
      rd_ent_o[j].bank_idx = MAX_SEL_W'(sel_q[rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]]);
    end
  end

endmodule

// File: rtl/mpram_lvt_core.sv
// Multi-port RAM: one bank per write agent, replicated per read port, steered by an LVT.
// Optional MPRAM_BYPASS_EN forwards a same-edge winning write to a matching read.
module mpram_lvt_core
  import mpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int NB_WRAGENT = 3,
  parameter int NB_RDAGENT = 2
) (
  input logic             aclk,
  input logic             areset,
  mpram_lvt_core_if.slave bus
);

  logic                  lvt_ready;
  logic [NB_WRAGENT-1:0] wr_win;
  logic [NB_WRAGENT-1:0] wr_coll;
  lvt_entry_t            rd_ent [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] rd_en_g;

  logic [DATA_WIDTH-1:0] bank_q [NB_WRAGENT][NB_RDAGENT][RAM_DEPTH];
  logic [DATA_WIDTH-1:0] rddata_d [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] rdunw_d;

  logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata_q;
  logic [NB_RDAGENT-1:0]            rdvalid_q;
  logic [NB_RDAGENT-1:0]            rdunw_q;
  logic [NB_WRAGENT-1:0]            wrcoll_q;

  mpram_lvt #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH),
    .NB_WRAGENT (NB_WRAGENT),
    .NB_RDAGENT (NB_RDAGENT)
  ) u_lvt (
    .clk_i     (aclk),
    .rst_i     (areset),
    .wr_en_i   (bus.wren),
    .wr_addr_i (bus.wraddr),
    .rd_addr_i (bus.rdaddr),
    .ready_o   (lvt_ready),
    .wr_win_o  (wr_win),
    .wr_coll_o (wr_coll),
    .rd_ent_o  (rd_ent)
  );

  assign rd_en_g = bus.rden & {NB_RDAGENT{lvt_ready}};

  // Every read port owns a private copy of each write agent's bank
  always_ff @(posedge aclk) begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int j = 0; j < NB_RDAGENT; j++) begin
        if (wr_win[i])
          bank_q[i][j][bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wrdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdunw_d = '0;
    for (int j = 0; j < NB_RDAGENT; j++) begin
      rddata_d[j] = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (rd_ent[j].bank_idx == MAX_SEL_W'(i))
          rddata_d[j] = bank_q[i][j][bus.rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]];
      end
      rdunw_d[j] = ~rd_ent[j].written;
      if (rdunw_d[j])
        rddata_d[j] = '0;
`ifdef MPRAM_BYPASS_EN
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (wr_win[i] &&
            bus.wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == bus.rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]) begin
          rddata_d[j] = bus.wrdata[i*DATA_WIDTH +: DATA_WIDTH];
          rdunw_d[j]  = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rdvalid_q <= '0;
      rdunw_q   <= '0;
      rddata_q  <= '0;
      wrcoll_q  <= '0;
    end else begin
      rdvalid_q <= rd_en_g;
      rdunw_q   <= rd_en_g & rdunw_d;
      wrcoll_q  <= wr_coll;
      for (int j = 0; j < NB_RDAGENT; j++)
        rddata_q[j*DATA_WIDTH +: DATA_WIDTH] <= rd_en_g[j] ? rddata_d[j] : '0;
    end
  end

  assign bus.ready       = lvt_ready;
  assign bus.wrcollision = wrcoll_q;
  assign bus.rdvalid     = rdvalid_q;
  assign bus.rdunwritten = rdunw_q;
  assign bus.rddata      = rddata_q;

endmodule

// File: tb/tb_mpram_lvt_core.sv
// Bench for mpram_lvt_core: vector table plus reset/INIT and sweep sequences, scoreboarded reads.
module tb_mpram_lvt_core;
  localparam int AW = 4, DW = 8, NW = 3, NR = 2, DEPTH = 16;

  typedef struct {
    logic [NW-1:0]    wren;
    logic [NW*AW-1:0] wraddr;
    logic [NW*DW-1:0] wrdata;
    logic [NR-1:0]    rden;
    logic [NR*AW-1:0] rdaddr;
    logic [NW-1:0]    coll;
  } vec_t;

  typedef struct {
    int          port;
    logic [DW-1:0] dat;
    logic        unw;
  } exp_t;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  mpram_lvt_core_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(NW), .NB_RDAGENT(NR)) bus ();

  mpram_lvt_core #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .NB_WRAGENT(NW), .NB_RDAGENT(NR)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int            checks = 0;
  int            errors = 0;
  exp_t          sb_q[$];
  logic [DW-1:0] mem_m [DEPTH];
  bit            wr_m  [DEPTH];
  int            vld_cnt [NR];
  vec_t          tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] wren, input logic [3:0] wa0, wa1, wa2,
                              input logic [7:0] wd0, wd1, wd2, input logic [1:0] rden,
                              input logic [3:0] ra0, ra1, input logic [2:0] coll);
    vec_t v;
    v.wren = wren; v.wraddr = {wa2, wa1, wa0}; v.wrdata = {wd2, wd1, wd0};
    v.rden = rden; v.rdaddr = {ra1, ra0}; v.coll = coll;
    return v;
  endfunction

  function automatic bit wins(input vec_t v, input int i);
    if (!v.wren[i]) return 1'b0;
    for (int k = 0; k < i; k++)
      if (v.wren[k] && v.wraddr[k*AW +: AW] == v.wraddr[i*AW +: AW]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) begin
      mem_m[a] = '0;
      wr_m[a]  = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t        e;
    logic [AW-1:0] a;
    bit          ev;
    bus.wren = v.wren; bus.wraddr = v.wraddr; bus.wrdata = v.wrdata;
    bus.rden = v.rden; bus.rdaddr = v.rdaddr;
    for (int j = 0; j < NR; j++) begin
      if (v.rden[j]) begin
        a = v.rdaddr[j*AW +: AW];
        e.port = j;
        e.dat  = wr_m[a] ? mem_m[a] : '0;
        e.unw  = !wr_m[a];
`ifdef MPRAM_BYPASS_EN
        for (int i = 0; i < NW; i++)
          if (wins(v, i) && v.wraddr[i*AW +: AW] == a) begin
            e.dat = v.wrdata[i*DW +: DW];
            e.unw = 1'b0;
          end
`endif
        sb_q.push_back(e);
      end
    end
    step();
    for (int j = 0; j < NR; j++) begin
      ev = (sb_q.size() > 0) && (sb_q[0].port == j);
      chk($sformatf("rdvalid[%0d]", j), 32'(bus.rdvalid[j]), 32'(ev));
      if (bus.rdvalid[j]) vld_cnt[j]++;
      if (ev) begin
        e = sb_q.pop_front();
        chk($sformatf("rddata[%0d]", j), 32'(bus.rddata[j*DW +: DW]), 32'(e.dat));
        chk($sformatf("rdunwritten[%0d]", j), 32'(bus.rdunwritten[j]), 32'(e.unw));
      end
    end
    chk("wrcollision", 32'(bus.wrcollision), 32'(v.coll));
    for (int i = 0; i < NW; i++)
      if (wins(v, i)) begin
        mem_m[v.wraddr[i*AW +: AW]] = v.wrdata[i*DW +: DW];
        wr_m[v.wraddr[i*AW +: AW]]  = 1'b1;
      end
  endtask

  // Traffic offered during INIT must be ignored; ready must take exactly DEPTH cycles
  task automatic wait_ready(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.wren = '1; bus.wraddr = '0; bus.wrdata = '1;
    bus.rden = '1; bus.rdaddr = '0;
    while (!done && n < 64) begin
      step();
      n++;
      chk("init_rdvalid", 32'(bus.rdvalid), 32'd0);
      if (bus.ready) done = 1'b1;
    end
    chk(name, n, DEPTH);
    bus.wren = '0; bus.rden = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 5, 0, 3'b000);
    tbl[1]  = mk(3'b010, 0, 3, 0, 8'h00, 8'hA5, 8'h00, 2'b00, 0, 0, 3'b000);
    tbl[2]  = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 3, 3, 3'b000);
    tbl[3]  = mk(3'b111, 7, 7, 7, 8'h11, 8'h22, 8'h33, 2'b00, 0, 0, 3'b110);
    tbl[4]  = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 7, 3, 3'b000);
    tbl[5]  = mk(3'b001, 9, 0, 0, 8'h01, 8'h00, 8'h00, 2'b00, 0, 0, 3'b000);
    tbl[6]  = mk(3'b100, 0, 0, 9, 8'h00, 8'h00, 8'h5A, 2'b01, 9, 0, 3'b000);
    tbl[7]  = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 9, 9, 3'b000);
    tbl[8]  = mk(3'b111, 1, 4, 6, 8'hC1, 8'hC4, 8'hC6, 2'b11, 1, 4, 3'b000);
    tbl[9]  = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 6, 1, 3'b000);
    tbl[10] = mk(3'b111, 13, 13, 12, 8'hE0, 8'hE1, 8'hD2, 2'b00, 0, 0, 3'b010);
    tbl[11] = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 13, 12, 3'b000);
    tbl[12] = mk(3'b111, 14, 15, 14, 8'h40, 8'h41, 8'h42, 2'b00, 0, 0, 3'b100);
    tbl[13] = mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 14, 15, 3'b000);

    areset = 1'b1;
    bus.wren = '0; bus.wraddr = '0; bus.wrdata = '0;
    bus.rden = '0; bus.rdaddr = '0;
    clear_model();
    step();
    step();
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_wrcollision", 32'(bus.wrcollision), 32'd0);
    chk("rst_rdvalid", 32'(bus.rdvalid), 32'd0);
    chk("rst_rdunwritten", 32'(bus.rdunwritten), 32'd0);
    chk("rst_rddata", 32'(bus.rddata), 32'd0);
    areset = 1'b0;
    wait_ready("init_cycles");

    for (int t = 0; t < 14; t++) run_vec(tbl[t]);

    // Full write sweep, then back-to-back reads on both ports
    for (int a = 0; a < DEPTH; a++)
      run_vec(mk(3'(1 << (a % 3)), 4'(a), 4'(a), 4'(a), 8'(a*7+16), 8'(a*7+16), 8'(a*7+16),
                 2'b00, 0, 0, 3'b000));
    vld_cnt[0] = 0;
    vld_cnt[1] = 0;
    for (int a = 0; a < DEPTH; a++)
      run_vec(mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 4'(a), 4'(15 - a), 3'b000));
    chk("sweep_vld0", vld_cnt[0], DEPTH);
    chk("sweep_vld1", vld_cnt[1], DEPTH);

    // Reset in the same cycle as a write and a read
    bus.wren = 3'b001; bus.wraddr = {4'd0, 4'd0, 4'd2}; bus.wrdata = {8'h00, 8'h00, 8'h77};
    bus.rden = 2'b01; bus.rdaddr = {4'd0, 4'd2};
    areset = 1'b1;
    step();
    chk("midrst_rdvalid", 32'(bus.rdvalid), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    areset = 1'b0;
    clear_model();
    sb_q.delete();
    wait_ready("reinit_cycles");
    run_vec(mk(3'b000, 0, 0, 0, 8'h00, 8'h00, 8'h00, 2'b11, 2, 3, 3'b000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
